// File: rtl/axis_pkg.sv
// axis_pkg: shared FSM state type and width helper for the stream upsizer
package axis_pkg;
  typedef enum logic {FILL, FLUSH_PEND} upsizer_state_e;
  typedef struct packed {
    logic [15:0] mask_w;
    logic [15:0] cnt_w;
  } upsizer_widths_t;
  // Mask has one bit per lane; the count must reach RATIO itself, hence +1.
  function automatic upsizer_widths_t upsizer_widths(input int ratio);
    upsizer_widths_t w;
    w.mask_w = 16'(ratio);
    w.cnt_w = 16'($clog2(ratio) + 1);
    return w;
  endfunction
endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg: output holding register; ports clk, rstn, load/d in, ready in, valid/q/free out
module axis_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] q,
  output logic         free
);
  assign free = !valid || ready;
  // A load while the old word handshakes keeps valid high for back-to-back words.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      q <= '0;
    end else begin
      valid <= load ? 1'b1 : (ready ? 1'b0 : valid);
      if (load) q <= d;
    end
  end
endmodule

// File: rtl/axis_upsizer.sv
// axis_upsizer: packs RATIO DLEN-bit beats into one word; ports in i_tvalid/i_tdata/i_flush, out o_tvalid/o_tdata/o_tmask/o_busy
module axis_upsizer
  import axis_pkg::*;
#(
  parameter int DLEN = 8,
  parameter int RATIO = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_tvalid,
  output logic                  o_tready,
  input  logic [DLEN-1:0]       i_tdata,
  input  logic                  i_flush,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic [DLEN*RATIO-1:0] o_tdata,
  output logic [RATIO-1:0]      o_tmask,
  output logic                  o_busy
);
  localparam upsizer_widths_t WID = upsizer_widths(RATIO);
  localparam int MW = int'(WID.mask_w);
  localparam int CW = int'(WID.cnt_w);
  localparam int DW = DLEN * RATIO;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);
  upsizer_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] acc, merged;
  logic [MW-1:0] mask;
  logic free, take, load, flush_ok;
  assign take = i_tvalid && o_tready;
  // Accumulator lanes above cnt are always zero, so a partial word needs no masking.
  always_comb begin
    merged = acc;
    if (take) merged[cnt*DLEN +: DLEN] = i_tdata;
    cnt_n = cnt + CW'(take);
  end
  assign flush_ok = i_flush && cnt_n != '0;
  assign mask = ~({MW{1'b1}} << cnt_n);
  assign o_busy = cnt != '0 || state == FLUSH_PEND;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= FILL;
    else state <= state_n;
  end
  always_comb
    state_n = state == FILL ? (flush_ok && !free ? FLUSH_PEND : FILL) : (free ? FILL : FLUSH_PEND);
  // A last beat is only accepted when the output is free, so a full word never waits.
  always_comb begin
    o_tready = state == FLUSH_PEND ? 1'b0 : (cnt == LAST ? free : 1'b1);
    load = free && (state == FLUSH_PEND || flush_ok || (take && cnt == LAST));
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      acc <= '0;
    end else if (load) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      cnt <= cnt_n;
      acc <= merged;
    end
  end
  axis_out_reg #(.W(DW + MW)) u_out (
    .clk(clk),
    .rstn(rstn),
    .load(load),
    .d({merged, mask}),
    .ready(i_tready),
    .valid(o_tvalid),
    .q({o_tdata, o_tmask}),
    .free(free)
  );
endmodule

// File: tb/tb_axis_upsizer.sv
// tb_axis_upsizer: scoreboard bench for axis_upsizer with DLEN=8, RATIO=4
module tb_axis_upsizer;
  logic clk = 0, rstn = 0;
  logic i_tvalid = 0, i_flush = 0, i_tready = 1;
  logic [7:0] i_tdata = 0;
  logic o_tready, o_tvalid, o_busy;
  logic [31:0] o_tdata;
  logic [3:0] o_tmask;
  int n_chk = 0, n_pass = 0, waits = 0;
  logic [35:0] q[$];
  logic [31:0] macc = 0;
  int mn = 0;
  logic hold = 0;
  logic [35:0] prev = 0;
  axis_upsizer #(.DLEN(8), .RATIO(4)) dut (
    .clk(clk), .rstn(rstn), .i_tvalid(i_tvalid), .o_tready(o_tready),
    .i_tdata(i_tdata), .i_flush(i_flush), .o_tvalid(o_tvalid),
    .i_tready(i_tready), .o_tdata(o_tdata), .o_tmask(o_tmask), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic model_flush();
    logic [3:0] m;
    m = 4'((1 << mn) - 1);
    if (mn != 0) q.push_back({macc, m});
    macc = 0;
    mn = 0;
  endtask
  task automatic model_add(input logic [7:0] d);
    macc[mn*8 +: 8] = d;
    mn++;
    if (mn == 4) model_flush();
  endtask
  task automatic beat(input logic [7:0] d, input logic fl = 0);
    int k = 0;
    i_tvalid = 1;
    i_tdata = d;
    #1;
    while (!o_tready && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("beat_accept", o_tready, 1);
    waits += k;
    i_flush = fl;
    model_add(d);
    if (fl) model_flush();
    @(negedge clk);
    i_tvalid = 0;
    i_flush = 0;
  endtask
  task automatic flush();
    i_flush = 1;
    @(negedge clk);
    i_flush = 0;
    model_flush();
  endtask
  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("drain", q.size(), 0);
  endtask
  always @(negedge clk) begin
    #1;
    if (!rstn) hold = 0;
    else begin
      if (hold) chk("stable", {o_tdata, o_tmask}, prev);
      hold = o_tvalid && !i_tready;
      prev = {o_tdata, o_tmask};
      if (o_tvalid && i_tready) begin
        if (q.size() == 0) chk("unexpected_word", q.size(), 1);
        else chk("word", {o_tdata, o_tmask}, q.pop_front());
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", o_tvalid, 0);
    chk("rst_data", o_tdata, 0);
    chk("rst_mask", o_tmask, 0);
    chk("rst_busy", o_busy, 0);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    #1;
    chk("ready_after_rst", o_tready, 1);
    @(negedge clk);
    beat(8'h55);
    beat(8'h66);
    chk("busy_partial", o_busy, 1);
    rstn = 0;
    macc = 0;
    mn = 0;
    q.delete();
    #1;
    chk("midrst_valid", o_tvalid, 0);
    chk("midrst_data", o_tdata, 0);
    chk("midrst_mask", o_tmask, 0);
    chk("midrst_busy", o_busy, 0);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) beat(8'(i));
    drain();
    waits = 0;
    for (int i = 'h10; i <= 'h17; i++) beat(8'(i));
    chk("stream_bubbles", waits, 0);
    drain();
    i_tready = 0;
    for (int i = 0; i < 7; i++) beat(8'(i));
    fork
      beat(8'h07);
      begin
        #2;
        chk("bp_ready_low", o_tready, 0);
        chk("bp_held_data", o_tdata, 32'h03020100);
        repeat (3) @(negedge clk);
        i_tready = 1;
      end
    join
    drain();
    beat(8'hAA);
    beat(8'hBB);
    flush();
    drain();
    flush();
    repeat (3) @(negedge clk);
    #1;
    chk("empty_flush_valid", o_tvalid, 0);
    chk("empty_flush_busy", o_busy, 0);
    @(negedge clk);
    i_tready = 0;
    for (int i = 'h20; i <= 'h23; i++) beat(8'(i));
    beat(8'hCC, 1);
    #1;
    chk("pend_ready", o_tready, 0);
    chk("pend_busy", o_busy, 1);
    chk("pend_valid", o_tvalid, 1);
    repeat (2) @(negedge clk);
    i_tready = 1;
    drain();
    #1;
    chk("post_pend_busy", o_busy, 0);
    chk("post_pend_ready", o_tready, 1);
    chk("post_pend_valid", o_tvalid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
